// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller.
//   gate_state_t : FSM state encoding (IDLE=0, ENTER=1, EXIT=2, GUARD=3)
//   MAX_SPOTS    : largest legal free-spot count
//   FREE_W       : width of the free_cnt bus
//   max_int()    : helper used to size the shared open/guard counter
package parking_pkg;

  localparam int MAX_SPOTS = 8;
  localparam int FREE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2,
    GUARD = 2'd3
  } gate_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable up-counter with terminal-count compare, shared by the open
// window and the guard interval.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count to 0 on the next edge
//   term       : terminal value for the current interval
//   done       : count has reached term (combinational compare)
module gate_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] term,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == term);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (!done) begin
      // Holding at term means the count can never wrap inside a state.
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: one FSM arbitrates entry/exit requests, keeps
// the selected barrier raised until the car passes or the open window
// expires, then holds both barriers down for a guard interval.
// Optional feature: define PARKING_STATS_EN to add saturating pass counters.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   free_cnt[3:0]  : free spots from the occupancy stage (legal 0..8)
//   entry_req      : car waiting at entry (level)
//   exit_req       : car waiting at exit (level, wins over entry)
//   car_passed     : one-cycle beam-sensor pulse
//   gate_in_open   : entry barrier raised (high exactly in ENTER)
//   gate_out_open  : exit barrier raised (high exactly in EXIT)
//   full           : registered, free_cnt == 0
//   timeout        : one-cycle pulse when the open window expires unused
//   err            : registered, free_cnt > 8
//   state[1:0]     : current FSM state for debug/LEDs
//   entries_total, exits_total [7:0] : completed passes (PARKING_STATS_EN only)
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES  = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREE_W-1:0] free_cnt,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic              car_passed,
  output logic              gate_in_open,
  output logic              gate_out_open,
  output logic              full,
  output logic              timeout,
  output logic              err,
  output logic [1:0]        state
`ifdef PARKING_STATS_EN
  ,
  output logic [7:0]        entries_total,
  output logic [7:0]        exits_total
`endif
);

  localparam int CNT_W = $clog2(max_int(max_int(OPEN_CYCLES, GUARD_CYCLES), 2));

  gate_state_t      state_q, state_d;
  logic             load, done;
  logic [CNT_W-1:0] term;

  // Both the open window and the guard interval count from 0 to their length-1.
  assign term = (state_q == GUARD) ? CNT_W'(GUARD_CYCLES - 1)
                                   : CNT_W'(OPEN_CYCLES - 1);

  // Reload on every state change and keep the count parked at 0 while idle.
  assign load = (state_d != state_q) || (state_q == IDLE);

  gate_timer #(.WIDTH(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .term  (term),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exit_req) begin
          state_d = EXIT;
        end else if (entry_req && (free_cnt != '0) &&
                     (free_cnt <= FREE_W'(MAX_SPOTS)) && !err) begin
          state_d = ENTER;
        end
      end
      ENTER, EXIT: begin
        if (car_passed) begin
          state_d = GUARD;
        end else if (done) begin
          state_d = GUARD;
          timeout = 1'b1;
        end
      end
      GUARD: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pure decodes of the state flop: the async reset lowers both barriers at
  // once, with no clock edge required.
  assign gate_in_open  = (state_q == ENTER);
  assign gate_out_open = (state_q == EXIT);
  assign state         = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      err  <= 1'b0;
    end else begin
      full <= (free_cnt == '0);
      err  <= (free_cnt > FREE_W'(MAX_SPOTS));
    end
  end

`ifdef PARKING_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_total <= '0;
      exits_total   <= '0;
    end else begin
      if (state_q == ENTER && car_passed && entries_total != 8'hFF)
        entries_total <= entries_total + 8'd1;
      if (state_q == EXIT && car_passed && exits_total != 8'hFF)
        exits_total <= exits_total + 8'd1;
    end
  end
`endif

endmodule
